// File: rtl/bus_pkg.sv
// Shared bus types and widths used by bus_if, bus_demux and the error responder.
package bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} bus_command_e;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} bus_status_e;
  typedef enum logic {ERR_IDLE = 1'b0, ERR_RESPOND = 1'b1} err_state_e;
endpackage

// File: rtl/bus_if.sv
// Valid/ready request and response channel; master drives requests, slave answers.
interface bus_if;
  import bus_pkg::*;

  logic                request_valid;
  logic                request_ready;
  bus_command_e        command;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   write_data;
  logic [STRB_W-1:0]   strobe;
  logic                response_valid;
  logic                response_ready;
  logic [DATA_W-1:0]   read_data;
  bus_status_e         status;

  modport master (
    output request_valid, command, address, write_data, strobe, response_ready,
    input  request_ready, response_valid, read_data, status
  );

  modport slave (
    input  request_valid, command, address, write_data, strobe, response_ready,
    output request_ready, response_valid, read_data, status
  );
endinterface

// File: rtl/bus_error_responder.sv
// Target for unmapped addresses: accepts one request, then returns an ERROR response.
module bus_error_responder
  import bus_pkg::*;
(
  input logic  i_clk,
  input logic  i_rst,
  bus_if.slave slave_if
);
  err_state_e state_q, state_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ERR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    slave_if.request_ready  = 1'b0;
    slave_if.response_valid = 1'b0;
    case (state_q)
      ERR_IDLE: begin
        slave_if.request_ready = 1'b1;
        if (slave_if.request_valid) state_d = ERR_RESPOND;
      end
      ERR_RESPOND: begin
        slave_if.response_valid = 1'b1;
        if (slave_if.response_ready) state_d = ERR_IDLE;
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  assign slave_if.read_data = '0;
  assign slave_if.status    = ERROR;

  // Payload is irrelevant here: neither reads nor writes have side effects.
  logic unused_payload;
  assign unused_payload = ^{slave_if.command, slave_if.address,
                            slave_if.write_data, slave_if.strobe};
endmodule

// File: rtl/bus_demux.sv
// Address-decoded 1-to-MASTERS bus splitter with in-order response tracking;
// unmapped addresses are answered by an internal error responder.
module bus_demux
  import bus_pkg::*;
#(
  parameter int                MASTERS         = 2,
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS [MASTERS] = '{32'h0000_0000, 32'h0001_0000},
  parameter logic [ADDR_W-1:0] ADDRESS_MASK [MASTERS] = '{32'hFFFF_0000, 32'hFFFF_0000}
) (
  input logic   i_clk,
  input logic   i_rst,
  bus_if.slave  slave_if,
  bus_if.master master_if [MASTERS]
);
  localparam int TGT_W = $clog2(MASTERS + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TGT_W-1:0] ERR_IDX = TGT_W'(MASTERS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [TGT_W-1:0] sel;
  logic [TGT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             busy, stall, req_fire, rsp_fire;

  // Index MASTERS is the internal error target.
  logic [MASTERS:0]             tgt_req_valid, tgt_req_ready;
  logic [MASTERS:0]             tgt_rsp_valid, tgt_rsp_ready;
  logic [MASTERS:0][DATA_W-1:0] tgt_rdata;
  logic [MASTERS:0]             tgt_status;

  logic              req_ready_mux, rsp_valid_mux, status_mux;
  logic [DATA_W-1:0] rdata_mux;

  // Lowest index wins on overlapping windows.
  always_comb begin
    sel = ERR_IDX;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if ((slave_if.address & ADDRESS_MASK[i]) == BASE_ADDRESS[i]) sel = TGT_W'(i);
    end
  end

  assign busy  = (outstanding_q != '0);
  assign stall = i_rst | (outstanding_q == CNT_MAX) | (busy & (sel != active_q));

  always_comb begin
    req_ready_mux = 1'b0;
    rsp_valid_mux = 1'b0;
    rdata_mux     = '0;
    status_mux    = 1'b0;
    for (int i = 0; i <= MASTERS; i++) begin
      if (sel == TGT_W'(i)) req_ready_mux = tgt_req_ready[i];
      if (active_q == TGT_W'(i)) begin
        rsp_valid_mux = tgt_rsp_valid[i];
        rdata_mux     = tgt_rdata[i];
        status_mux    = tgt_status[i];
      end
    end
  end

  assign slave_if.request_ready  = req_ready_mux & ~stall;
  // Responses with nothing outstanding are never forwarded.
  assign slave_if.response_valid = rsp_valid_mux & busy;
  assign slave_if.read_data      = rdata_mux;
  assign slave_if.status         = bus_status_e'(status_mux);

  assign req_fire = slave_if.request_valid & slave_if.request_ready;
  assign rsp_fire = slave_if.response_valid & slave_if.response_ready;

  for (genvar gi = 0; gi <= MASTERS; gi++) begin : g_steer
    assign tgt_req_valid[gi] = slave_if.request_valid & ~stall & (sel == TGT_W'(gi));
    assign tgt_rsp_ready[gi] = slave_if.response_ready & busy & (active_q == TGT_W'(gi));
  end

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_tgt
    assign master_if[gi].request_valid  = tgt_req_valid[gi];
    assign master_if[gi].command        = slave_if.command;
    assign master_if[gi].address        = slave_if.address;
    assign master_if[gi].write_data     = slave_if.write_data;
    assign master_if[gi].strobe         = slave_if.strobe;
    assign master_if[gi].response_ready = tgt_rsp_ready[gi];
    assign tgt_req_ready[gi]            = master_if[gi].request_ready;
    assign tgt_rsp_valid[gi]            = master_if[gi].response_valid;
    assign tgt_rdata[gi]                = master_if[gi].read_data;
    assign tgt_status[gi]               = master_if[gi].status;
  end

  bus_if err_if ();

  assign err_if.request_valid  = tgt_req_valid[MASTERS];
  assign err_if.command        = slave_if.command;
  assign err_if.address        = slave_if.address;
  assign err_if.write_data     = slave_if.write_data;
  assign err_if.strobe         = slave_if.strobe;
  assign err_if.response_ready = tgt_rsp_ready[MASTERS];
  assign tgt_req_ready[MASTERS] = err_if.request_ready;
  assign tgt_rsp_valid[MASTERS] = err_if.response_valid;
  assign tgt_rdata[MASTERS]     = err_if.read_data;
  assign tgt_status[MASTERS]    = err_if.status;

  bus_error_responder u_err (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .slave_if (err_if)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    active_d      = active_q;
    if (req_fire) active_d = sel;
    if (req_fire && !rsp_fire)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!req_fire && rsp_fire) outstanding_d = outstanding_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding_q <= '0;
      active_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      active_q      <= active_d;
    end
  end
endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: routing, error target, outstanding limit,
// target-switch ordering and mid-operation reset.
module tb_bus_demux;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_if up_if ();
  bus_if dn_if [2] ();

  int n_tests = 0;
  int n_fail  = 0;

  bus_demux #(
    .MASTERS         (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .slave_if  (up_if),
    .master_if (dn_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bus_command_e cmd, input logic [31:0] addr, input logic [31:0] wd);
    up_if.request_valid = 1'b1;
    up_if.command       = cmd;
    up_if.address       = addr;
    up_if.write_data    = wd;
    up_if.strobe        = 4'hF;
  endtask

  initial begin
    up_if.request_valid   = 1'b0;
    up_if.command         = READ;
    up_if.address         = 32'h0;
    up_if.write_data      = 32'h0;
    up_if.strobe          = 4'hF;
    up_if.response_ready  = 1'b1;
    dn_if[0].request_ready  = 1'b1;
    dn_if[0].response_valid = 1'b0;
    dn_if[0].read_data      = 32'h0;
    dn_if[0].status         = OKAY;
    dn_if[1].request_ready  = 1'b1;
    dn_if[1].response_valid = 1'b0;
    dn_if[1].read_data      = 32'h0;
    dn_if[1].status         = OKAY;

    // Reset holds every downstream valid low even with an upstream request.
    req(READ, 32'h0000_0010, 32'h0);
    #1;
    chk("rst_dn0_valid", dn_if[0].request_valid, 0);
    chk("rst_dn1_valid", dn_if[1].request_valid, 0);
    chk("rst_rsp_valid", up_if.response_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    up_if.request_valid = 1'b0;
    #1;
    chk("rst_outstanding", dut.outstanding_q, 0);
    chk("rst_err_state", dut.u_err.state_q, ERR_IDLE);
    tick();

    // READ routed to target 0, response returned combinationally.
    req(READ, 32'h0000_0010, 32'h0);
    #1;
    chk("rd_dn0_valid", dn_if[0].request_valid, 1);
    chk("rd_dn1_valid", dn_if[1].request_valid, 0);
    chk("rd_dn0_addr", dn_if[0].address, 32'h0000_0010);
    chk("rd_req_ready", up_if.request_ready, 1);
    tick();
    up_if.request_valid = 1'b0;
    dn_if[0].response_valid = 1'b1;
    dn_if[0].read_data      = 32'hCAFE_0001;
    #1;
    chk("rd_rsp_valid", up_if.response_valid, 1);
    chk("rd_rsp_data", up_if.read_data, 32'hCAFE_0001);
    chk("rd_rsp_status", up_if.status, OKAY);
    chk("rd_dn0_rsp_ready", dn_if[0].response_ready, 1);
    chk("rd_dn1_rsp_ready", dn_if[1].response_ready, 0);
    tick();
    dn_if[0].response_valid = 1'b0;

    // WRITE routed to target 1.
    req(WRITE, 32'h0001_0020, 32'hA5A5_1234);
    #1;
    chk("wr_dn1_valid", dn_if[1].request_valid, 1);
    chk("wr_dn0_valid", dn_if[0].request_valid, 0);
    chk("wr_dn1_cmd", dn_if[1].command, WRITE);
    chk("wr_dn1_wdata", dn_if[1].write_data, 32'hA5A5_1234);
    tick();
    up_if.request_valid = 1'b0;
    dn_if[1].response_valid = 1'b1;
    dn_if[1].read_data      = 32'h1234_5678;
    #1;
    chk("wr_rsp_data", up_if.read_data, 32'h1234_5678);
    chk("wr_dn1_rsp_ready", dn_if[1].response_ready, 1);
    tick();
    dn_if[1].response_valid = 1'b0;
    #1;
    chk("wr_outstanding", dut.outstanding_q, 0);

    // Unmapped address: answered internally one cycle after the handshake.
    req(READ, 32'h0005_0000, 32'h0);
    #1;
    chk("um_dn0_valid", dn_if[0].request_valid, 0);
    chk("um_dn1_valid", dn_if[1].request_valid, 0);
    chk("um_req_ready", up_if.request_ready, 1);
    chk("um_rsp_early", up_if.response_valid, 0);
    tick();
    up_if.request_valid = 1'b0;
    #1;
    chk("um_rsp_valid", up_if.response_valid, 1);
    chk("um_rsp_status", up_if.status, ERROR);
    chk("um_rsp_data", up_if.read_data, 32'h0);
    tick();
    #1;
    chk("um_rsp_done", up_if.response_valid, 0);
    chk("um_outstanding", dut.outstanding_q, 0);

    // Outstanding limit: four accepted, the fifth waits for one response.
    req(READ, 32'h0000_0100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lim_accept%0d", k), up_if.request_ready, 1);
      tick();
    end
    #1;
    chk("lim_outstanding4", dut.outstanding_q, 4);
    chk("lim_full_ready", up_if.request_ready, 0);
    chk("lim_full_dn0", dn_if[0].request_valid, 0);
    dn_if[0].response_valid = 1'b1;
    dn_if[0].read_data      = 32'h0000_00D0;
    #1;
    chk("lim_rsp_valid", up_if.response_valid, 1);
    chk("lim_same_cycle_ready", up_if.request_ready, 0);
    tick();
    dn_if[0].response_valid = 1'b0;
    #1;
    chk("lim_fifth_ready", up_if.request_ready, 1);
    chk("lim_fifth_dn0", dn_if[0].request_valid, 1);
    tick();
    up_if.request_valid = 1'b0;
    #1;
    chk("lim_refill", dut.outstanding_q, 4);
    dn_if[0].response_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("lim_drain%0d", k), up_if.response_valid, 1);
      tick();
    end
    dn_if[0].response_valid = 1'b0;
    #1;
    chk("lim_empty", dut.outstanding_q, 0);

    // Target switch stalls until target 0 has drained, responses in order.
    req(READ, 32'h0000_0200, 32'h0);
    #1; chk("sw_t0_a", up_if.request_ready, 1);
    tick();
    #1; chk("sw_t0_b", up_if.request_ready, 1);
    tick();
    req(READ, 32'h0001_0004, 32'h0);
    #1;
    chk("sw_stall_ready", up_if.request_ready, 0);
    chk("sw_stall_dn1", dn_if[1].request_valid, 0);
    dn_if[0].response_valid = 1'b1;
    dn_if[0].read_data      = 32'h0000_00A1;
    #1;
    chk("sw_rsp1", up_if.read_data, 32'h0000_00A1);
    tick();
    dn_if[0].read_data = 32'h0000_00A2;
    #1;
    chk("sw_rsp2", up_if.read_data, 32'h0000_00A2);
    chk("sw_stall_last", up_if.request_ready, 0);
    tick();
    dn_if[0].response_valid = 1'b0;
    #1;
    chk("sw_accept_ready", up_if.request_ready, 1);
    chk("sw_accept_dn1", dn_if[1].request_valid, 1);
    tick();
    up_if.request_valid = 1'b0;
    dn_if[1].response_valid = 1'b1;
    dn_if[1].read_data      = 32'h0000_00B1;
    #1;
    chk("sw_rsp3", up_if.read_data, 32'h0000_00B1);
    chk("sw_dn0_rsp_ready", dn_if[0].response_ready, 0);
    tick();
    dn_if[1].response_valid = 1'b0;
    #1;
    chk("sw_empty", dut.outstanding_q, 0);

    // Reset while the error responder holds a response.
    up_if.response_ready = 1'b0;
    req(READ, 32'h0005_0000, 32'h0);
    #1; chk("rerr_ready", up_if.request_ready, 1);
    tick();
    up_if.request_valid = 1'b0;
    tick();
    #1;
    chk("rerr_held_valid", up_if.response_valid, 1);
    chk("rerr_state", dut.u_err.state_q, ERR_RESPOND);
    rst = 1'b1;
    #1;
    chk("rerr_state_clr", dut.u_err.state_q, ERR_IDLE);
    chk("rerr_valid_clr", up_if.response_valid, 0);
    rst = 1'b0;
    up_if.response_ready = 1'b1;
    tick();

    // Reset with three requests outstanding.
    req(READ, 32'h0000_0300, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rmid_accept%0d", k), up_if.request_ready, 1);
      tick();
    end
    up_if.request_valid = 1'b0;
    #1;
    chk("rmid_outstanding3", dut.outstanding_q, 3);
    rst = 1'b1;
    #1;
    chk("rmid_outstanding0", dut.outstanding_q, 0);
    chk("rmid_err_idle", dut.u_err.state_q, ERR_IDLE);
    rst = 1'b0;
    tick();
    req(WRITE, 32'h0001_0040, 32'h0000_0055);
    #1;
    chk("rmid_next_dn1", dn_if[1].request_valid, 1);
    chk("rmid_next_dn0", dn_if[0].request_valid, 0);
    chk("rmid_next_ready", up_if.request_ready, 1);
    tick();
    up_if.request_valid = 1'b0;
    dn_if[1].response_valid = 1'b1;
    dn_if[1].read_data      = 32'h0000_0077;
    #1;
    chk("rmid_next_rsp", up_if.read_data, 32'h0000_0077);
    tick();
    dn_if[1].response_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
